menu_controller: RTL and testbench
==================================

// Module: menu_controller
// PURPOSE
//  Menu controller for the four-entry on-screen menu: LENNA=0, BOATS=1, BARBARA=2, FILTER=3.
//  - Debounces the up/down/ok push-buttons.
//  - Moves the cursor, which is shown to the pixel generator through selectImage.
//  - Commits the image choice.
//  - Sequences the filter processor through a start/done handshake.
//  Sits between the board buttons, the VGA sync (frame_start) and the filter datapath.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable synced cycles needed to accept a level change
//  CNT_W            19      debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk           in   1  system clock; the only clock
//  reset         in   1  synchronous, active-high reset
//  btn_up        in   1  raw button, asynchronous, active-high
//  btn_down      in   1  raw button, asynchronous, active-high
//  btn_ok        in   1  raw button, asynchronous, active-high
//  frame_start   in   1  1-cycle pulse at start of vertical blank, from the sync generator
//  filter_done   in   1  1-cycle pulse from the filter processor: job finished
//  selectImage   out  2  cursor position for display; changes only on frame_start
//  image_sel     out  2  committed image index (0..2) presented to the filter/frame source
//  filter_start  out  1  1-cycle pulse requesting a filter job on image_sel
//  busy          out  1  high from filter_start until filter_done is accepted
// BEHAVIOUR
//  Reset:
//  - reset=1 at a clk edge: selectImage=0, image_sel=0, filter_start=0, busy=0.
//  - Internal cursor=0, FSM=IDLE.
//  - Synchronizers, debounced levels and counters all 0 (buttons treated as released).
//  - Applies in any state, including WAIT; an in-flight filter job is abandoned.
//  Input conditioning, per button:
//  - 2-FF synchronizer.
//  - Counter clears whenever synced level == debounced level; otherwise it increments.
//  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level
//    flips on the next edge and the counter clears.
//  - Press event = debounced 0->1, registered as a 1-cycle pulse.
//  - Raw rise held stable -> press pulse high exactly DEBOUNCE_CYCLES+3 cycles later.
//  - Releases generate no event.
//  Cursor (IDLE only):
//  - up pulse: cursor-1 mod 4 (0 wraps to 3). down pulse: cursor+1 mod 4 (3 wraps to 0).
//  - up and down pulses in the same cycle: both ignored.
//  - ok in the same cycle as up or down: ok ignored; the move is taken only if it is the sole direction pulse.
//  - selectImage <= cursor on every frame_start pulse, visible the cycle after.
//  - frame_start coinciding with a cursor move: selectImage takes the pre-move value.
//  FSM states: IDLE, START, WAIT.
//  - IDLE, ok pulse, cursor<3: image_sel <= cursor; stay in IDLE; no filter_start.
//  - IDLE, ok pulse, cursor==3: go to START; image_sel unchanged.
//  - START: filter_start=1 for exactly this one cycle, busy=1; go to WAIT unconditionally.
//    A filter_done seen in START is ignored.
//  - WAIT: busy=1. filter_done -> IDLE; busy=0 on the following cycle.
//    All button pulses are discarded, never queued. selectImage keeps updating on frame_start.
//  - filter_done in IDLE: ignored.
//  - image_sel never changes while busy=1.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Reset: assert reset 3 cycles with buttons high.
//     -> All outputs 0; no press events until buttons release and re-press after reset.
//  2. Hold btn_down 12 cycles.
//     -> Press pulse 7 cycles after the rise; cursor=1; selectImage stays 0.
//     -> frame_start pulse -> selectImage=1 the next cycle.
//  3. Wrap: up from cursor 0 -> cursor 3; down from 3 -> 0, each checked via frame_start.
//     Simultaneous up+down -> cursor unchanged.
//  4. Glitch rejection: 2-cycle and 3-cycle raw pulses on btn_up -> no event, cursor unchanged.
//  5. Commit: cursor=2, press ok -> image_sel=2, filter_start never high, busy=0.
//  6. Filter job: cursor=3, press ok.
//     -> filter_start high exactly 1 cycle, image_sel=2 held, busy=1.
//     -> Presses during WAIT are ignored.
//     -> filter_done -> busy=0 next cycle.
//     -> Reset asserted in WAIT instead -> busy=0, FSM in IDLE, image_sel=0.

Source files
------------

// File: rtl/menu_controller.sv
// rtl/menu_controller.sv - menu cursor, image commit and filter job sequencer
// Debounced up/down/ok buttons drive a 4-entry cursor; the FILTER entry launches a start/done job.
module menu_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  input  logic       frame_start,
  input  logic       filter_done,
  output logic [1:0] selectImage,
  output logic [1:0] image_sel,
  output logic       filter_start,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button lanes: bit 0 = up, bit 1 = down, bit 2 = ok.
  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]       deb_q, deb_d, deb_prev_q, deb_prev_d, press_q, press_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  state_t     state_q, state_d;
  logic [1:0] cursor_q, cursor_d, select_image_q, select_image_d, image_sel_q, image_sel_d;
  logic       filter_start_q, filter_start_d, busy_q, busy_d;
  logic       mv_up, mv_dn, ok_take;

  assign raw = {btn_ok, btn_down, btn_up};

  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    press_d    = deb_q & ~deb_prev_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = ~deb_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Opposing direction pulses cancel each other; ok only counts when no direction pulse.
  assign mv_up   = press_q[0] & ~press_q[1];
  assign mv_dn   = press_q[1] & ~press_q[0];
  assign ok_take = press_q[2] & ~press_q[0] & ~press_q[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ok_take && cursor_q == 2'd3) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (filter_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cursor_d       = cursor_q;
    image_sel_d    = image_sel_q;
    select_image_d = frame_start ? cursor_q : select_image_q;
    filter_start_d = (state_d == START);
    busy_d         = (state_d != IDLE);
    if (state_q == IDLE) begin
      if (mv_up)                                cursor_d    = cursor_q - 2'd1;
      else if (mv_dn)                           cursor_d    = cursor_q + 2'd1;
      else if (ok_take && cursor_q != 2'd3)     image_sel_d = cursor_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_q          <= '0;
      deb_prev_q     <= '0;
      press_q        <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q        <= IDLE;
      cursor_q       <= '0;
      select_image_q <= '0;
      image_sel_q    <= '0;
      filter_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      deb_q          <= deb_d;
      deb_prev_q     <= deb_prev_d;
      press_q        <= press_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q        <= state_d;
      cursor_q       <= cursor_d;
      select_image_q <= select_image_d;
      image_sel_q    <= image_sel_d;
      filter_start_q <= filter_start_d;
      busy_q         <= busy_d;
    end
  end

  assign selectImage  = select_image_q;
  assign image_sel    = image_sel_q;
  assign filter_start = filter_start_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_menu_controller.sv
// tb/tb_menu_controller.sv - scoreboard bench for menu_controller
// Stimulus tasks push expectations from a menu-level model; a monitor pops them on frame/job events.
module tb_menu_controller;
  localparam int DEB = 4;
  localparam int K_UP = 0, K_DN = 1, K_OK = 2, K_UPDN = 3, K_OKUP = 4;

  logic       clk = 1'b0;
  logic       reset, btn_up, btn_down, btn_ok, frame_start, filter_done;
  logic [1:0] selectImage, image_sel;
  logic       filter_start, busy;

  typedef struct {int sel; int img; int bsy;} exp_t;
  exp_t exp_q[$];
  int   job_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_cur = 0;
  int   m_img = 0;
  int   m_busy = 0;
  bit   fs_at_edge = 1'b0;
  bit   fst_prev = 1'b0;

  menu_controller #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_ok(btn_ok),
    .frame_start(frame_start), .filter_done(filter_done), .selectImage(selectImage),
    .image_sel(image_sel), .filter_start(filter_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Menu-level reference: a press registers only if held at least DEB cycles.
  task automatic model_press(input int kind, input int h);
    bit up, dn, ok;
    up = (kind == K_UP) || (kind == K_UPDN) || (kind == K_OKUP);
    dn = (kind == K_DN) || (kind == K_UPDN);
    ok = (kind == K_OK) || (kind == K_OKUP);
    if (h < DEB || m_busy != 0 || (up && dn)) return;
    if (up)      m_cur = (m_cur + 3) % 4;
    else if (dn) m_cur = (m_cur + 1) % 4;
    else if (ok) begin
      if (m_cur < 3) m_img = m_cur;
      else begin
        m_busy = 1;
        job_q.push_back(m_img);
      end
    end
  endtask

  task automatic press(input int kind, input int h);
    model_press(kind, h);
    btn_up   = (kind == K_UP) || (kind == K_UPDN) || (kind == K_OKUP);
    btn_down = (kind == K_DN) || (kind == K_UPDN);
    btn_ok   = (kind == K_OK) || (kind == K_OKUP);
    repeat (h) @(posedge clk);
    #1;
    btn_up = 1'b0; btn_down = 1'b0; btn_ok = 1'b0;
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    exp_q.push_back('{m_cur, m_img, m_busy});
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic done_pulse();
    filter_done = 1'b1;
    @(posedge clk); #1;
    filter_done = 1'b0;
    if (m_busy != 0) begin
      check("busy_after_done", busy, 0);
      m_busy = 0;
    end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    fs_at_edge <= frame_start;
    fst_prev   <= filter_start;
  end

  always @(negedge clk) begin
    exp_t e;
    int   j;
    if (fs_at_edge) begin
      if (exp_q.size() == 0) note_fail("frame_without_expectation");
      else begin
        e = exp_q.pop_front();
        check("selectImage", selectImage, e.sel);
        check("image_sel", image_sel, e.img);
        check("busy", busy, e.bsy);
      end
    end
    if (filter_start) begin
      check("filter_start_width", fst_prev, 0);
      if (!fst_prev) begin
        if (job_q.size() == 0) note_fail("filter_start_unexpected");
        else begin
          j = job_q.pop_front();
          check("job_image_sel", image_sel, j);
          check("job_busy", busy, 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int r, h;
    reset = 1'b1; btn_up = 1'b1; btn_down = 1'b1; btn_ok = 1'b1;
    frame_start = 1'b0; filter_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_selectImage", selectImage, 0);
    check("rst_image_sel", image_sel, 0);
    check("rst_filter_start", filter_start, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_ok = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    frame();

    // Exact press latency: frame at edge 7 sees the pre-move cursor, edge 8 the new one.
    model_press(K_DN, 12);
    btn_down = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 6) begin exp_q.push_back('{0, 0, 0}); frame_start = 1'b1; end
      if (i == 7) exp_q.push_back('{1, 0, 0});
      if (i == 8) frame_start = 1'b0;
      if (i == 11) btn_down = 1'b0;
    end
    repeat (14) @(posedge clk);
    #1;

    press(K_UP, 6);   frame();
    press(K_UP, 6);   frame();
    press(K_DN, 6);   frame();
    press(K_UPDN, 6); frame();
    press(K_UP, 2);   press(K_UP, 3); frame();
    press(K_DN, 5);   press(K_DN, 5); press(K_OK, 5); frame();
    press(K_DN, 5);   frame();

    // Job with a filter_done landing in START, which must be ignored.
    model_press(K_OK, 7);
    btn_ok = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (i == 6) btn_ok = 1'b0;
      if (filter_start) found = 1'b1;
    end
    btn_ok = 1'b0;
    check("job_started", found, 1);
    if (found) begin
      filter_done = 1'b1;
      @(posedge clk); #1;
      filter_done = 1'b0;
      check("done_in_start_ignored", busy, 1);
    end
    repeat (14) @(posedge clk);
    #1;
    press(K_DN, 6); press(K_OK, 6); frame();
    done_pulse();
    frame();

    // Reset while waiting on a job.
    press(K_OK, 6); frame();
    reset = 1'b1;
    @(posedge clk); #1;
    check("wait_rst_busy", busy, 0);
    check("wait_rst_image_sel", image_sel, 0);
    check("wait_rst_selectImage", selectImage, 0);
    check("wait_rst_filter_start", filter_start, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_cur = 0; m_img = 0; m_busy = 0;
    press(K_DN, 6); frame();

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      h = $urandom_range(2, 7);
      case (r)
        0, 1:    press(K_UP, h);
        2, 3:    press(K_DN, h);
        4, 5, 9: press(K_OK, h);
        6:       press(K_UPDN, h);
        7:       press(K_OKUP, h);
        default: done_pulse();
      endcase
      frame();
    end
    if (m_busy != 0) begin
      done_pulse();
      frame();
    end
    repeat (4) @(posedge clk);
    #1;
    check("frames_drained", exp_q.size(), 0);
    check("jobs_drained", job_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
